// File: rtl/udp_test_seq.sv
// udp_test_seq: UDP test-traffic sequencer in the GMII transmit clock domain.
// Resolves the peer MAC via ARP (bounded retries with timeout), then streams
// UDP packets whose payload is an incrementing counter, a PRBS-8 sequence, or
// an echo of the last received UDP payload. Honours a programmable gap, an
// optional packet limit and mac_top transmit-buffer backpressure.
//
// Ports:
//   gmii_tx_clk, rst          clock, asynchronous active-high reset
//   enable                    run request (level)
//   mode, payload_len         payload source and length for counter/PRBS
//   gap_cycles, pkt_limit     inter-packet gap, packet limit (0 = unlimited)
//   pattern_seed              counter start / PRBS seed
//   arp_request_req           one-cycle ARP request pulse
//   mac_send_end, arp_found   ARP frame sent / reply resolved
//   mac_not_exist             cached peer MAC invalid
//   almost_full               transmit buffer almost full
//   udp_tx_req, udp_ram_data_req   UDP send handshake
//   ram_wr_en, ram_wr_data    payload byte stream
//   udp_send_data_length      payload length of the current packet
//   udp_rec_*                 received-payload RAM access
//   pkt_cnt, busy, arp_fail   status
module udp_test_seq #(
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned GAP_W       = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MAX_LEN     = 1472,
  parameter int unsigned ARP_TIMEOUT = 125000000,
  parameter int unsigned MAX_ARP_TRY = 4
) (
  input  logic             gmii_tx_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] payload_len,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic [CNT_W-1:0] pkt_limit,
  input  logic [7:0]       pattern_seed,
  output logic             arp_request_req,
  input  logic             mac_send_end,
  input  logic             arp_found,
  input  logic             mac_not_exist,
  input  logic             almost_full,
  output logic             udp_tx_req,
  input  logic             udp_ram_data_req,
  output logic             ram_wr_en,
  output logic [7:0]       ram_wr_data,
  output logic [15:0]      udp_send_data_length,
  input  logic             udp_rec_data_valid,
  input  logic [15:0]      udp_rec_data_length,
  output logic [10:0]      udp_rec_ram_read_addr,
  input  logic [7:0]       udp_rec_ram_rdata,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             busy,
  output logic             arp_fail
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARP_REQ, S_ARP_SEND, S_ARP_WAIT, S_GAP,
    S_CHECK, S_GEN_REQ, S_WRITE, S_DONE, S_FAIL
  } state_t;

  localparam logic [15:0]      MAX_LEN_V   = 16'(MAX_LEN);
  localparam logic [GAP_W-1:0] ARP_TO_LAST = GAP_W'(ARP_TIMEOUT - 1);
  localparam logic [7:0]       ARP_TRY_V   = 8'(MAX_ARP_TRY);
  localparam logic [GAP_W-1:0] GAP_ONE     = GAP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [GAP_W-1:0] timer;
  logic [7:0]       retry;
  logic [15:0]      idx;
  logic [1:0]       mode_q;
  logic [7:0]       seed_q;
  logic [7:0]       lfsr;
  logic [7:0]       data_q;
  logic             echo_q;

  logic [31:0]      pl_ext;
  logic [31:0]      rl_ext;
  logic [31:0]      len_raw;
  logic [15:0]      len_calc;
  logic             len_skip;
  logic [7:0]       byte_k;
  logic [7:0]       lfsr_next;

  always_comb begin
    pl_ext  = 32'(payload_len);
    rl_ext  = 32'(udp_rec_data_length);
    len_raw = '0;
    len_skip = 1'b0;
    if (mode == 2'd2) begin
      len_raw  = (rl_ext < 32'd8) ? '0 : (rl_ext - 32'd8);
      len_skip = !udp_rec_data_valid || (len_raw == '0);
    end else begin
      len_raw  = (pl_ext == '0) ? 32'd1 : pl_ext;
    end
    len_calc = (len_raw > 32'(MAX_LEN)) ? MAX_LEN_V : len_raw[15:0];
  end

  // x^8+x^6+x^5+x^4+1, shifting left
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_comb begin
    byte_k = seed_q + idx[7:0];
    if (mode_q == 2'd1)
      byte_k = lfsr;
  end

  assign arp_request_req       = (state == S_ARP_REQ);
  assign udp_tx_req            = (state == S_GEN_REQ);
  assign busy                  = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
  assign udp_rec_ram_read_addr = idx[10:0];
  // Echo bytes come straight from the RAM output register: address k is
  // issued in cycle k, its data is valid in cycle k+1, the same cycle the
  // registered wr_en for byte k is high.
  assign ram_wr_data           = echo_q ? udp_rec_ram_rdata : data_q;

  always_ff @(posedge gmii_tx_clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      timer                <= '0;
      retry                <= '0;
      idx                  <= '0;
      mode_q               <= '0;
      seed_q               <= '0;
      lfsr                 <= '0;
      data_q               <= '0;
      echo_q               <= 1'b0;
      ram_wr_en            <= 1'b0;
      udp_send_data_length <= '0;
      pkt_cnt              <= '0;
      arp_fail             <= 1'b0;
    end else begin
      ram_wr_en <= 1'b0;
      echo_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            pkt_cnt  <= '0;
            retry    <= '0;
            arp_fail <= 1'b0;
            state    <= S_ARP_REQ;
          end
        end
        S_ARP_REQ: begin
          state <= enable ? S_ARP_SEND : S_IDLE;
        end
        S_ARP_SEND: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (mac_send_end) begin
            timer <= '0;
            state <= S_ARP_WAIT;
          end
        end
        S_ARP_WAIT: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (arp_found) begin
            timer <= '0;
            state <= S_GAP;
          end else if (timer == ARP_TO_LAST) begin
            retry <= retry + 8'd1;
            if (retry + 8'd1 == ARP_TRY_V) begin
              arp_fail <= 1'b1;
              state    <= S_FAIL;
            end else begin
              state <= S_ARP_REQ;
            end
          end else begin
            timer <= timer + GAP_ONE;
          end
        end
        S_GAP: begin
          if (!enable)
            state <= S_IDLE;
          else if (timer >= gap_cycles)
            state <= S_CHECK;
          else
            timer <= timer + GAP_ONE;
        end
        S_CHECK: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (pkt_limit != '0 && pkt_cnt == pkt_limit) begin
            state <= S_DONE;
          end else if (mac_not_exist) begin
            retry <= '0;
            state <= S_ARP_REQ;
          end else if (almost_full) begin
            state <= S_CHECK;
          end else if (len_skip) begin
            timer <= '0;
            state <= S_GAP;
          end else begin
            udp_send_data_length <= len_calc;
            mode_q <= mode;
            seed_q <= pattern_seed;
            lfsr   <= (pattern_seed == 8'h00) ? 8'h01 : pattern_seed;
            idx    <= '0;
            state  <= S_GEN_REQ;
          end
        end
        S_GEN_REQ: begin
          if (udp_ram_data_req)
            state <= S_WRITE;
        end
        S_WRITE: begin
          ram_wr_en <= 1'b1;
          data_q    <= byte_k;
          echo_q    <= (mode_q == 2'd2);
          if (mode_q == 2'd1)
            lfsr <= lfsr_next;
          if (idx == udp_send_data_length - 16'd1) begin
            idx     <= '0;
            pkt_cnt <= pkt_cnt + CNT_ONE;
            timer   <= '0;
            state   <= S_GAP;
          end else begin
            idx <= idx + 16'd1;
          end
        end
        S_DONE, S_FAIL: begin
          if (!enable)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
